// File: rtl/clkdiv_prog.sv
// Multi-channel programmable clock divider / tick generator with glitch-free shadowed divisor updates.
// Optional macro CLKDIV_SYNC_EN adds a sync_in port that phase-aligns all enabled channels.
module clkdiv_prog #(
    parameter int CHANNELS    = 2,
    parameter int CNT_W       = 28,
    parameter int DEFAULT_DIV = 500000
) (
    input  logic                      clock_in,
    input  logic                      rst_n,
`ifdef CLKDIV_SYNC_EN
    input  logic                      sync_in,
`endif
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*CNT_W-1:0] div_val,
    input  logic [CHANNELS*CNT_W-1:0] high_val,
    output logic [CHANNELS-1:0]       clock_out,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       pending
);

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEFAULT_DIV / 2);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    logic sync;
`ifdef CLKDIV_SYNC_EN
    assign sync = sync_in;
`else
    assign sync = 1'b0;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] high_q, high_d;
        logic [CNT_W-1:0] sh_div_q, sh_div_d;
        logic [CNT_W-1:0] sh_high_q, sh_high_d;
        logic [CNT_W-1:0] ld_div, ld_high;
        logic             pend_q, pend_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             at_end, apply;

        // Clamp at capture so the active values always give a toggling output.
        always_comb begin
            ld_div  = div_val[i*CNT_W +: CNT_W];
            ld_high = high_val[i*CNT_W +: CNT_W];
            if (ld_div < TWO)
                ld_div = TWO;
            if (ld_high == '0)
                ld_high = ONE;
            if (ld_high >= ld_div)
                ld_high = ld_div - ONE;
        end

        // NOTE: every always_comb output gets a default first so no latch is inferred.
        always_comb begin
            at_end = (cnt_q == div_q - ONE);
            apply  = pend_q && (!enable[i] || at_end || sync);
            cnt_d  = '0;
            clk_d  = 1'b0;
            tick_d = 1'b0;
            if (enable[i]) begin
                clk_d = (cnt_q < high_q);
                if (sync) begin
                    cnt_d = '0;
                end else if (cnt_q >= div_q - ONE) begin
                    cnt_d  = '0;
                    tick_d = at_end;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            // A same-cycle load lands in the shadow while the old shadow goes active.
            div_d     = apply ? sh_div_q : div_q;
            high_d    = apply ? sh_high_q : high_q;
            sh_div_d  = load[i] ? ld_div : sh_div_q;
            sh_high_d = load[i] ? ld_high : sh_high_q;
            pend_d    = load[i] || (pend_q && !apply);
        end

        // NOTE: state registers use non-blocking assignments so all channels update in lockstep.
        always_ff @(posedge clock_in or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q     <= '0;
                div_q     <= DIV_RST;
                high_q    <= HIGH_RST;
                sh_div_q  <= DIV_RST;
                sh_high_q <= HIGH_RST;
                pend_q    <= 1'b0;
                clk_q     <= 1'b0;
                tick_q    <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                div_q     <= div_d;
                high_q    <= high_d;
                sh_div_q  <= sh_div_d;
                sh_high_q <= sh_high_d;
                pend_q    <= pend_d;
                clk_q     <= clk_d;
                tick_q    <= tick_d;
            end
        end

        assign clock_out[i] = clk_q;
        assign tick[i]      = tick_q;
        assign pending[i]   = pend_q;
    end

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed bench for clkdiv_prog (2 channels, 8-bit counters, default divisor 10).
// Waveforms are captured as bit strings, oldest sample in the MSB, and compared to hand-derived patterns.
module tb_clkdiv_prog;

    localparam int CH = 2;
    localparam int W  = 8;

    logic              clock_in = 1'b0;
    logic              rst_n;
    logic [CH-1:0]     enable;
    logic [CH-1:0]     load;
    logic [CH*W-1:0]   div_val;
    logic [CH*W-1:0]   high_val;
    logic [CH-1:0]     clock_out;
    logic [CH-1:0]     tick;
    logic [CH-1:0]     pending;
`ifdef CLKDIV_SYNC_EN
    logic              sync_in;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] cap_c0, cap_c1, cap_t0, cap_t1, cap_p0, cap_p1;

    clkdiv_prog #(.CHANNELS(CH), .CNT_W(W), .DEFAULT_DIV(10)) dut (
        .clock_in  (clock_in),
        .rst_n     (rst_n),
`ifdef CLKDIV_SYNC_EN
        .sync_in   (sync_in),
`endif
        .enable    (enable),
        .load      (load),
        .div_val   (div_val),
        .high_val  (high_val),
        .clock_out (clock_out),
        .tick      (tick),
        .pending   (pending)
    );

    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %b required %b", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [W-1:0] d, input logic [W-1:0] h);
        div_val[ch*W +: W]  = d;
        high_val[ch*W +: W] = h;
        load[ch]            = 1'b1;
    endtask

    // Runs n edges; load (and sync) are one-cycle strobes cleared after the first edge.
    task automatic capture(input int n);
        cap_c0 = '0; cap_c1 = '0; cap_t0 = '0; cap_t1 = '0; cap_p0 = '0; cap_p1 = '0;
        for (int k = 0; k < n; k++) begin
            step();
            load = '0;
`ifdef CLKDIV_SYNC_EN
            sync_in = 1'b0;
`endif
            cap_c0 = {cap_c0[62:0], clock_out[0]};
            cap_c1 = {cap_c1[62:0], clock_out[1]};
            cap_t0 = {cap_t0[62:0], tick[0]};
            cap_t1 = {cap_t1[62:0], tick[1]};
            cap_p0 = {cap_p0[62:0], pending[0]};
            cap_p1 = {cap_p1[62:0], pending[1]};
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = '0;
        load     = '0;
        div_val  = '0;
        high_val = '0;
`ifdef CLKDIV_SYNC_EN
        sync_in  = 1'b0;
`endif
        repeat (3) step();
        check("reset_clock_out", 64'(clock_out), 64'(2'b00));
        check("reset_tick",      64'(tick),      64'(2'b00));
        check("reset_pending",   64'(pending),   64'(2'b00));

        // Default period 10: 5 high, 5 low, tick on the wrap.
        rst_n  = 1'b1;
        enable = 2'b11;
        capture(20);
        check("dflt_c0", cap_c0, 64'(20'b11111000001111100000));
        check("dflt_c1", cap_c1, 64'(20'b11111000001111100000));
        check("dflt_t0", cap_t0, 64'(20'b00000000010000000001));
        check("dflt_t1", cap_t1, 64'(20'b00000000010000000001));

        // Ch0 load div=4 high=1 at counter=3; applied at the wrap.
        capture(3);
        set_ch(0, 8'd4, 8'd1);
        capture(15);
        check("ld4_c0", cap_c0, 64'(15'b110000010001000));
        check("ld4_t0", cap_t0, 64'(15'b000000100010001));
        check("ld4_p0", cap_p0, 64'(15'b111111000000000));
        check("ld4_c1", cap_c1, 64'(15'b110000011111000));
        check("ld4_t1", cap_t1, 64'(15'b000000100000000));
        check("ld4_p1", cap_p1, 64'(15'b000000000000000));

        // div=0, high=0 clamps to div=2, high=1.
        set_ch(0, 8'd0, 8'd0);
        capture(8);
        check("clamp2_c0", cap_c0, 64'(8'b10001010));
        check("clamp2_t0", cap_t0, 64'(8'b00010101));
        check("clamp2_p0", cap_p0, 64'(8'b11100000));

        // div=6, high=9 clamps high to 5.
        set_ch(0, 8'd6, 8'd9);
        capture(14);
        check("clamp6_c0", cap_c0, 64'(14'b10111110111110));
        check("clamp6_t0", cap_t0, 64'(14'b01000001000001));
        check("clamp6_p0", cap_p0, 64'(14'b10000000000000));

        // Load A pending, load B coincident with the wrap: A applies, B waits one more period.
        set_ch(0, 8'd3, 8'd1);
        capture(5);
        check("dbl_pre_c0", cap_c0, 64'(5'b11111));
        check("dbl_pre_p0", cap_p0, 64'(5'b11111));
        set_ch(0, 8'd4, 8'd2);
        capture(8);
        check("dbl_c0", cap_c0, 64'(8'b01001100));
        check("dbl_t0", cap_t0, 64'(8'b10010001));
        check("dbl_p0", cap_p0, 64'(8'b11100000));

        // Ch1 disabled with a pending div=3 load: outputs drop, load applies immediately.
        set_ch(1, 8'd3, 8'd1);
        capture(1);
        check("dis_pre_p1", cap_p1, 64'(1'b1));
        check("dis_pre_c1", cap_c1, 64'(1'b1));
        enable = 2'b01;
        capture(3);
        check("dis_c1", cap_c1, 64'(3'b000));
        check("dis_t1", cap_t1, 64'(3'b000));
        check("dis_p1", cap_p1, 64'(3'b000));
        enable = 2'b11;
        capture(7);
        check("reen_c1", cap_c1, 64'(7'b1001001));
        check("reen_t1", cap_t1, 64'(7'b0010010));

`ifdef CLKDIV_SYNC_EN
        // ch0 div=10, ch1 div=5, applied while disabled, then sync pulses at arbitrary phase and at a wrap.
        enable = 2'b00;
        set_ch(0, 8'd10, 8'd5);
        set_ch(1, 8'd5, 8'd2);
        capture(2);
        check("sync_setup_p", {cap_p1[1:0], cap_p0[1:0]}, 64'(4'b1010));
        enable = 2'b11;
        capture(7);
        sync_in = 1'b1;
        capture(1);
        check("sync1_t", {cap_t1[0], cap_t0[0]}, 64'(2'b00));
        capture(9);
        check("sync1_c0", cap_c0, 64'(9'b111110000));
        check("sync1_c1", cap_c1, 64'(9'b110001100));
        check("sync1_t0", cap_t0, 64'(9'b000000000));
        check("sync1_t1", cap_t1, 64'(9'b000010000));
        sync_in = 1'b1;
        capture(1);
        check("sync2_t", {cap_t1[0], cap_t0[0]}, 64'(2'b00));
        capture(5);
        check("sync2_c0", cap_c0, 64'(5'b11111));
        check("sync2_c1", cap_c1, 64'(5'b11000));
        check("sync2_t1", cap_t1, 64'(5'b00001));
`endif

        // Mid-period reset with loads pending: outputs clear at once, period 10 restored.
        set_ch(0, 8'd3, 8'd1);
        set_ch(1, 8'd3, 8'd1);
        capture(1);
        check("prerst_p", 64'(pending), 64'(2'b11));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_clock_out", 64'(clock_out), 64'(2'b00));
        check("midrst_tick",      64'(tick),      64'(2'b00));
        check("midrst_pending",   64'(pending),   64'(2'b00));
        step();
        rst_n = 1'b1;
        capture(20);
        check("postrst_c0", cap_c0, 64'(20'b11111000001111100000));
        check("postrst_c1", cap_c1, 64'(20'b11111000001111100000));
        check("postrst_t0", cap_t0, 64'(20'b00000000010000000001));
        check("postrst_p0", cap_p0, 64'(20'b00000000000000000000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clkdiv_prog.md
Name: clkdiv_prog

Overview:
- Multi-channel programmable clock divider and tick generator. Replaces the single fixed-divisor divider.
- Each channel has its own runtime divisor and high-time, an enable, and a one-cycle tick strobe.
- Divisor and high-time updates are glitch-free: they take effect only at a period boundary.
- Feeds slow clocks and enables to pipeline debug, LED and peripheral logic from the FPGA board clock.

Parameters:
- CHANNELS, 2, number of independent divider channels.
- CNT_W, 28, width of the per-channel counter and of the divisor/high-time fields.
- DEFAULT_DIV, 500000, divisor loaded at reset. Must be >= 2 and < 2^CNT_W.

Ports:
- clock_in  input  1  board clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  CHANNELS  per-channel run enable.
- load  input  CHANNELS  per-channel strobe; captures div_val/high_val into that channel's shadow registers.
- div_val  input  CHANNELS*CNT_W  packed divisor. Channel i occupies [i*CNT_W +: CNT_W].
- high_val  input  CHANNELS*CNT_W  packed high-time in clock_in cycles, same packing as div_val.
- clock_out  output  CHANNELS  divided clock per channel.
- tick  output  CHANNELS  one-cycle pulse per completed period.
- pending  output  CHANNELS  shadow load waiting to be applied.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Counters = 0.
  - Active divisor = DEFAULT_DIV; active high-time = DEFAULT_DIV/2 (integer division).
  - Shadows = same values as active.
  - clock_out = 0, tick = 0, pending = 0.
- Per channel, when enable=1, each cycle:
  - If counter >= active_div-1: counter <= 0. Otherwise counter <= counter+1.
  - clock_out <= (counter < active_high), evaluated on the pre-update counter. This gives one cycle of registered latency.
  - tick <= (counter == active_div-1). This is exactly one pulse per period, coincident with the wrap.
- Load:
  - load[i]=1 captures div_val/high_val slice i into shadow and sets pending[i] the next cycle.
  - A second load before apply overwrites the shadow. pending stays 1.
- Apply:
  - When the counter wraps (counter == active_div-1 with enable=1) and pending=1: active <= shadow, pending <= 0.
  - The new values take effect from counter=0 of the next period. A period is never truncated or stretched mid-way.
- Simultaneous load and wrap in the same cycle: the wrap applies the previous shadow (if pending). The new shadow is captured and pending remains/becomes 1, to be applied at the next wrap.
- Clamping, applied at capture into shadow:
  - div < 2 → 2.
  - high = 0 → 1.
  - high >= div → div-1 (using the clamped div).
  - Hence clock_out always toggles while enabled.
- enable=0:
  - counter held at 0, clock_out <= 0, tick <= 0.
  - If pending=1, apply immediately on the next cycle.
  - On re-enable, the channel starts at counter 0; the first clock_out high appears 1 cycle after enable rises.
- Channels are fully independent. No shared state except clock/reset.
- Reset asserted mid-period: immediate return to reset values. Pending loads are discarded.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: CLKDIV_SYNC_EN.
- Defined:
  - Adds input port sync_in (1 bit).
  - sync_in=1 forces every enabled channel's counter to 0 on the next edge, which aligns the phases of all channels.
  - Any pending shadow is applied at the same edge.
  - tick is not asserted for the truncated period.
  - sync_in has priority over a simultaneous wrap; a same-cycle load is captured as normal.
- Undefined:
  - No sync_in port; channels free-run independently.

Test Plan:
All scenarios use CHANNELS=2, CNT_W=8, DEFAULT_DIV=10.
- Reset release, enable=2'b11 → each clock_out is 5 cycles high / 5 low, period 10. tick pulses every 10 cycles, on the cycle the counter = 9. Both channels identical.
- Ch0 load div=4, high=1 mid-period (counter=3) → pending[0]=1 until the wrap at counter=9. Then the period is 4 (1 high, 3 low) and pending[0]=0. Ch1 is unchanged at period 10.
- Load div=0, high=0 → clamped to div=2, high=1 (alternating 1/0). Load div=6, high=9 → high clamped to 5 (5 high, 1 low).
- Load asserted in the same cycle as the wrap while a prior load is pending → the first value applies at that wrap, the second at the following wrap. pending stays 1 across the wrap.
- enable[1] dropped with a pending load (div=3) → clock_out[1]=0 and tick[1]=0 next cycle, pending[1]=0 after 1 cycle. On re-enable the period is 3.
- CLKDIV_SYNC_EN defined: ch0 div=10, ch1 div=5, sync_in pulse at arbitrary phase → both counters are 0 on the next edge, no tick for that cycle, and rising clock_out edges are aligned afterwards. Also: rst_n pulsed low mid-period → outputs 0 immediately and period 10 restored.
